// File: rtl/word_guess_checker_if.sv
// ---------------------------------------------------------------------------
// word_guess_checker_if
// Bundles the keyboard-side inputs and the display-side status outputs of the
// word-guess engine so the engine and its driver share one connection.
//
// master : the side that types letters and loads targets (decoder / bench)
//   load_target, target_word, ascii, ascii_valid, backspace, submit  -> out
//   ascii_out, cur_len, status, result_valid, set, wrong, win, lose,
//   tries_left                                                       -> in
// slave  : the engine itself, with the directions reversed
// ---------------------------------------------------------------------------
interface word_guess_checker_if #(
    parameter int WORD_LEN = 5,
    parameter int CHAR_W   = 7,
    parameter int TRY_W    = 3
);
    logic                         load_target;
    logic [WORD_LEN*CHAR_W-1:0]   target_word;
    logic [CHAR_W-1:0]            ascii;
    logic                         ascii_valid;
    logic                         backspace;
    logic                         submit;

    logic [CHAR_W-1:0]            ascii_out;
    logic [3:0]                   cur_len;
    logic [2*WORD_LEN-1:0]        status;
    logic                         result_valid;
    logic                         set;
    logic                         wrong;
    logic                         win;
    logic                         lose;
    logic [TRY_W-1:0]             tries_left;

    modport master (
        output load_target, target_word, ascii, ascii_valid, backspace, submit,
        input  ascii_out, cur_len, status, result_valid, set, wrong, win, lose,
               tries_left
    );

    modport slave (
        input  load_target, target_word, ascii, ascii_valid, backspace, submit,
        output ascii_out, cur_len, status, result_valid, set, wrong, win, lose,
               tries_left
    );
endinterface

// File: rtl/word_guess_checker.sv
// ---------------------------------------------------------------------------
// word_guess_checker
// Wordle-style guess engine. Letters typed on the keyboard are buffered into
// a WORD_LEN-letter guess; on submit each letter is graded against the loaded
// target (exact / present elsewhere / absent, duplicate-aware), the remaining
// tries are counted down, and win or lose is declared.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous, active-low reset
//   bus  - word_guess_checker_if.slave:
//          inputs  load_target, target_word, ascii, ascii_valid, backspace,
//                  submit
//          outputs ascii_out, cur_len, status (2 bits per letter:
//                  10 exact, 01 present, 00 absent, 11 ungraded),
//                  result_valid, set, wrong, win, lose, tries_left
// ---------------------------------------------------------------------------
module word_guess_checker #(
    parameter int WORD_LEN  = 5,
    parameter int CHAR_W    = 7,
    parameter int MAX_TRIES = 6,
    parameter int TRY_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    word_guess_checker_if.slave  bus
);

    localparam int IDX_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_ENTRY        = 3'd1;
    localparam logic [2:0] S_EVAL_EXACT   = 3'd2;
    localparam logic [2:0] S_EVAL_PRESENT = 3'd3;
    localparam logic [2:0] S_REPORT       = 3'd4;
    localparam logic [2:0] S_DONE         = 3'd5;

    typedef logic [WORD_LEN-1:0][CHAR_W-1:0] word_t;

    logic [2:0]                state;
    word_t                     target;
    word_t                     guess;
    logic [3:0]                cur_len;
    logic [IDX_W-1:0]          idx;
    logic [WORD_LEN-1:0]       used;
    logic [WORD_LEN-1:0][1:0]  grade;
    logic [2*WORD_LEN-1:0]     status_q;
    logic [CHAR_W-1:0]         ascii_out_q;
    logic                      result_valid_q;
    logic                      wrong_q;
    logic                      win_q;
    logic                      lose_q;
    logic [TRY_W-1:0]          tries_q;

    // Character classification; upper case is folded by setting bit 5.
    logic                      is_lower;
    logic                      is_upper;
    logic [CHAR_W-1:0]         letter;
    logic                      buf_full;
    logic                      last_idx;
    logic                      all_exact;
    logic [TRY_W-1:0]          tries_dec;

    assign is_lower  = (bus.ascii >= CHAR_W'(7'h61)) && (bus.ascii <= CHAR_W'(7'h7a));
    assign is_upper  = (bus.ascii >= CHAR_W'(7'h41)) && (bus.ascii <= CHAR_W'(7'h5a));
    assign letter    = is_upper ? (bus.ascii | CHAR_W'(7'h20)) : bus.ascii;
    assign buf_full  = (cur_len == 4'(WORD_LEN));
    assign last_idx  = (idx == IDX_W'(WORD_LEN - 1));
    assign all_exact = (grade == {WORD_LEN{2'b10}});
    assign tries_dec = (tries_q == '0) ? '0 : tries_q - TRY_W'(1);

    // Present-elsewhere search for the guess letter at idx: find the lowest
    // target position not yet claimed by an exact match or an earlier
    // present match. Scanning downward lets the lowest hit win.
    logic                      found;
    logic [IDX_W-1:0]          match_j;

    always_comb begin
        found   = 1'b0;
        match_j = '0;
        for (int j = WORD_LEN - 1; j >= 0; j--) begin
            if (!used[j] && (target[j] == guess[idx])) begin
                found   = 1'b1;
                match_j = IDX_W'(j);
            end
        end
    end

    // Main engine: load_target overrides everything; otherwise the state
    // decides which inputs matter. Grading walks idx over the letters twice,
    // first for exact hits, then for present-elsewhere hits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            target         <= '0;
            guess          <= '0;
            cur_len        <= '0;
            idx            <= '0;
            used           <= '0;
            grade          <= '0;
            status_q       <= '1;
            ascii_out_q    <= '0;
            result_valid_q <= 1'b0;
            wrong_q        <= 1'b0;
            win_q          <= 1'b0;
            lose_q         <= 1'b0;
            tries_q        <= '0;
        end else begin
            result_valid_q <= 1'b0;
            wrong_q        <= 1'b0;
            if (bus.load_target) begin
                state    <= S_ENTRY;
                target   <= bus.target_word;
                guess    <= '0;
                cur_len  <= '0;
                idx      <= '0;
                used     <= '0;
                status_q <= '1;
                tries_q  <= TRY_W'(MAX_TRIES);
                win_q    <= 1'b0;
                lose_q   <= 1'b0;
            end else begin
                case (state)
                    S_ENTRY: begin
                        if (bus.backspace) begin
                            if (cur_len != 4'd0) begin
                                cur_len <= cur_len - 4'd1;
                            end else begin
                                wrong_q <= 1'b1;
                            end
                        end else if (bus.submit) begin
                            if (buf_full) begin
                                state <= S_EVAL_EXACT;
                                idx   <= '0;
                                used  <= '0;
                            end else begin
                                wrong_q <= 1'b1;
                            end
                        end else if (bus.ascii_valid) begin
                            if ((is_lower || is_upper) && !buf_full) begin
                                guess[cur_len[IDX_W-1:0]] <= letter;
                                cur_len                   <= cur_len + 4'd1;
                                ascii_out_q               <= letter;
                            end else begin
                                wrong_q <= 1'b1;
                            end
                        end
                    end
                    S_EVAL_EXACT: begin
                        if (guess[idx] == target[idx]) begin
                            grade[idx] <= 2'b10;
                            used[idx]  <= 1'b1;
                        end else begin
                            grade[idx] <= 2'b00;
                        end
                        if (last_idx) begin
                            idx   <= '0;
                            state <= S_EVAL_PRESENT;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    S_EVAL_PRESENT: begin
                        if ((grade[idx] != 2'b10) && found) begin
                            grade[idx]    <= 2'b01;
                            used[match_j] <= 1'b1;
                        end
                        if (last_idx) begin
                            idx   <= '0;
                            state <= S_REPORT;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    S_REPORT: begin
                        status_q       <= grade;
                        result_valid_q <= 1'b1;
                        tries_q        <= tries_dec;
                        if (all_exact) begin
                            win_q <= 1'b1;
                            state <= S_DONE;
                        end else if (tries_dec == '0) begin
                            lose_q <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            guess   <= '0;
                            cur_len <= '0;
                            state   <= S_ENTRY;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.ascii_out    = ascii_out_q;
    assign bus.cur_len      = cur_len;
    assign bus.status       = status_q;
    assign bus.result_valid = result_valid_q;
    assign bus.set          = (state == S_ENTRY);
    assign bus.wrong        = wrong_q;
    assign bus.win          = win_q;
    assign bus.lose         = lose_q;
    assign bus.tries_left   = tries_q;

endmodule

// File: tb/tb_word_guess_checker.sv
// ---------------------------------------------------------------------------
// tb_word_guess_checker
// Drives two engines (MAX_TRIES 6 and 2) with the same keyboard stream.
// Known games are checked from a vector table, entry and reset corner cases
// by hand-written sequences, and random games against a letter-count model.
// ---------------------------------------------------------------------------
module tb_word_guess_checker;

    typedef logic [4:0][6:0] word_t;

    typedef struct {
        string      tgt;
        string      gss;
        logic [9:0] exp_status;
        logic       exp_win;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        load_target;
    word_t       target_word;
    logic [6:0]  ascii;
    logic        ascii_valid;
    logic        backspace;
    logic        submit;

    int total;
    int bad;

    word_guess_checker_if #(.WORD_LEN(5), .CHAR_W(7), .TRY_W(3)) bus_a ();
    word_guess_checker_if #(.WORD_LEN(5), .CHAR_W(7), .TRY_W(3)) bus_b ();

    assign bus_a.load_target = load_target;
    assign bus_a.target_word = target_word;
    assign bus_a.ascii       = ascii;
    assign bus_a.ascii_valid = ascii_valid;
    assign bus_a.backspace   = backspace;
    assign bus_a.submit      = submit;
    assign bus_b.load_target = load_target;
    assign bus_b.target_word = target_word;
    assign bus_b.ascii       = ascii;
    assign bus_b.ascii_valid = ascii_valid;
    assign bus_b.backspace   = backspace;
    assign bus_b.submit      = submit;

    word_guess_checker #(.WORD_LEN(5), .CHAR_W(7), .MAX_TRIES(6), .TRY_W(3)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    word_guess_checker #(.WORD_LEN(5), .CHAR_W(7), .MAX_TRIES(2), .TRY_W(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case some wait is never satisfied.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic word_t toWord(input string s);
        word_t w;
        byte   b;
        for (int i = 0; i < 5; i++) begin
            b = s[i];
            w[i] = b[6:0];
        end
        return w;
    endfunction

    // Reference grading by letter counts: exact hits first, then each
    // remaining guess letter (left to right) consumes one unmatched copy of
    // that letter in the target.
    function automatic logic [9:0] refGrade(input word_t tgt, input word_t gs);
        int         remaining [26];
        logic [9:0] r;
        int         k;
        for (int i = 0; i < 26; i++) remaining[i] = 0;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            if (gs[i] == tgt[i]) begin
                r[2*i +: 2] = 2'b10;
            end else begin
                k = int'(tgt[i]) - 97;
                remaining[k]++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            k = int'(gs[i]) - 97;
            if (gs[i] != tgt[i] && remaining[k] > 0) begin
                r[2*i +: 2] = 2'b01;
                remaining[k]--;
            end
        end
        return r;
    endfunction

    task automatic loadWord(input word_t w);
        target_word = w;
        load_target = 1'b1;
        tick();
        load_target = 1'b0;
    endtask

    task automatic typeChar(input logic [6:0] c);
        ascii       = c;
        ascii_valid = 1'b1;
        tick();
        ascii_valid = 1'b0;
    endtask

    task automatic typeWord(input word_t w, input bit upper_mix);
        logic [6:0] c;
        for (int i = 0; i < 5; i++) begin
            c = w[i];
            if (upper_mix && ($urandom_range(0, 1) == 1)) c = c & 7'h5f;
            typeChar(c);
        end
    endtask

    // Counts edges after the submit edge until result_valid shows up.
    task automatic waitResult(input bit use_b, output int n);
        logic rv;
        n = 0;
        do begin
            tick();
            n++;
            rv = use_b ? bus_b.result_valid : bus_a.result_valid;
        end while (!rv && n < 40);
    endtask

    task automatic submitGuess(input bit use_b, output int n);
        submit = 1'b1;
        tick();
        submit = 1'b0;
        waitResult(use_b, n);
    endtask

    task automatic applyStimulus(input vec_t v);
        int n;
        loadWord(toWord(v.tgt));
        typeWord(toWord(v.gss), 1'b0);
        submitGuess(1'b0, n);
        checkOutput({"latency ", v.gss}, n, 11);
        checkOutput({"status ", v.gss}, bus_a.status, v.exp_status);
        checkOutput({"tries ", v.gss}, bus_a.tries_left, 5);
        checkOutput({"win ", v.gss}, bus_a.win, v.exp_win);
        tick();
        checkOutput({"rv_pulse ", v.gss}, bus_a.result_valid, 0);
    endtask

    vec_t vecs [4];

    initial begin
        int   n;
        bit   seen;
        word_t tw, gw;

        vecs[0] = '{tgt: "crane", gss: "caret", exp_status: 10'b00_01_01_01_10, exp_win: 1'b0};
        vecs[1] = '{tgt: "apple", gss: "ppppp", exp_status: 10'b00_00_10_10_00, exp_win: 1'b0};
        vecs[2] = '{tgt: "crane", gss: "eerie", exp_status: 10'b10_00_01_00_00, exp_win: 1'b0};
        vecs[3] = '{tgt: "crane", gss: "crane", exp_status: 10'b10_10_10_10_10, exp_win: 1'b1};

        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        load_target = 1'b0;
        target_word = '0;
        ascii       = '0;
        ascii_valid = 1'b0;
        backspace   = 1'b0;
        submit      = 1'b0;

        // Reset values
        #2 rst = 1'b0;
        #2;
        checkOutput("rst status", bus_a.status, 10'h3ff);
        checkOutput("rst cur_len", bus_a.cur_len, 0);
        checkOutput("rst ascii_out", bus_a.ascii_out, 0);
        checkOutput("rst set", bus_a.set, 0);
        checkOutput("rst tries", bus_a.tries_left, 0);
        checkOutput("rst flags", {bus_a.result_valid, bus_a.wrong, bus_a.win, bus_a.lose}, 0);
        checkOutput("rst b status", bus_b.status, 10'h3ff);
        tick();
        tick();
        rst = 1'b1;
        tick();
        checkOutput("idle set", bus_a.set, 0);

        $display("[TB] vector table");
        for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

        $display("[TB] entry corner cases");
        loadWord(toWord("crane"));
        checkOutput("load set", bus_a.set, 1);
        checkOutput("load tries", bus_a.tries_left, 6);
        checkOutput("load status", bus_a.status, 10'h3ff);
        typeChar(7'h43);
        typeChar(7'h52);
        checkOutput("fold ascii_out", bus_a.ascii_out, 7'h72);
        checkOutput("fold cur_len", bus_a.cur_len, 2);
        typeChar(7'h31);
        checkOutput("digit wrong", bus_a.wrong, 1);
        checkOutput("digit cur_len", bus_a.cur_len, 2);
        tick();
        checkOutput("wrong pulse", bus_a.wrong, 0);
        submit = 1'b1;
        tick();
        submit = 1'b0;
        checkOutput("short submit wrong", bus_a.wrong, 1);
        tick(); tick(); tick();
        checkOutput("short submit set", bus_a.set, 1);
        checkOutput("short submit rv", bus_a.result_valid, 0);
        backspace   = 1'b1;
        ascii       = 7'h61;
        ascii_valid = 1'b1;
        tick();
        backspace   = 1'b0;
        ascii_valid = 1'b0;
        checkOutput("bs priority cur_len", bus_a.cur_len, 1);
        checkOutput("bs priority wrong", bus_a.wrong, 0);
        backspace = 1'b1;
        tick();
        checkOutput("bs to zero", bus_a.cur_len, 0);
        tick();
        backspace = 1'b0;
        checkOutput("bs empty wrong", bus_a.wrong, 1);
        checkOutput("bs empty cur_len", bus_a.cur_len, 0);
        typeWord(toWord("crane"), 1'b0);
        checkOutput("full cur_len", bus_a.cur_len, 5);
        typeChar(7'h78);
        checkOutput("overflow wrong", bus_a.wrong, 1);
        checkOutput("overflow cur_len", bus_a.cur_len, 5);
        submitGuess(1'b0, n);
        checkOutput("win latency", n, 11);
        checkOutput("win status", bus_a.status, 10'b10_10_10_10_10);
        checkOutput("win flag", bus_a.win, 1);
        tick();
        checkOutput("done set", bus_a.set, 0);
        typeChar(7'h61);
        checkOutput("done ignore wrong", bus_a.wrong, 0);
        checkOutput("done ignore cur_len", bus_a.cur_len, 5);
        checkOutput("done hold win", bus_a.win, 1);

        $display("[TB] reset during evaluation");
        loadWord(toWord("crane"));
        typeWord(toWord("crane"), 1'b0);
        submit = 1'b1;
        tick();
        submit = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b0;
        #2;
        checkOutput("abort status", bus_a.status, 10'h3ff);
        checkOutput("abort cur_len", bus_a.cur_len, 0);
        checkOutput("abort ascii_out", bus_a.ascii_out, 0);
        checkOutput("abort tries", bus_a.tries_left, 0);
        checkOutput("abort flags", {bus_a.set, bus_a.wrong, bus_a.win, bus_a.lose}, 0);
        tick();
        tick();
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus_a.result_valid) seen = 1'b1;
        end
        checkOutput("abort no rv", seen, 0);
        checkOutput("abort idle set", bus_a.set, 0);

        $display("[TB] lose with two tries");
        loadWord(toWord("crane"));
        checkOutput("b load tries", bus_b.tries_left, 2);
        typeWord(toWord("zzzzz"), 1'b0);
        submitGuess(1'b1, n);
        checkOutput("b first latency", n, 11);
        checkOutput("b first tries", bus_b.tries_left, 1);
        checkOutput("b first lose", bus_b.lose, 0);
        checkOutput("b first status", bus_b.status, 0);
        tick();
        checkOutput("b first set", bus_b.set, 1);
        typeWord(toWord("zzzzz"), 1'b0);
        submitGuess(1'b1, n);
        checkOutput("b second latency", n, 11);
        checkOutput("b lose", bus_b.lose, 1);
        checkOutput("b lose tries", bus_b.tries_left, 0);
        checkOutput("b lose win", bus_b.win, 0);
        checkOutput("a tries after two", bus_a.tries_left, 4);
        submit = 1'b1;
        tick();
        submit = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (bus_b.result_valid || bus_b.wrong) seen = 1'b1;
        end
        checkOutput("b done ignores submit", seen, 0);
        checkOutput("b done holds tries", bus_b.tries_left, 0);
        checkOutput("b done holds lose", bus_b.lose, 1);
        loadWord(toWord("zzzzz"));
        checkOutput("b reload tries", bus_b.tries_left, 2);
        checkOutput("b reload lose", bus_b.lose, 0);
        checkOutput("b reload set", bus_b.set, 1);
        checkOutput("b reload status", bus_b.status, 10'h3ff);

        $display("[TB] random games");
        for (int g = 0; g < 20; g++) begin
            for (int i = 0; i < 5; i++) begin
                tw[i] = 7'(97 + $urandom_range(0, 3));
                gw[i] = 7'(97 + $urandom_range(0, 3));
            end
            loadWord(tw);
            typeWord(gw, 1'b1);
            submitGuess(1'b0, n);
            checkOutput($sformatf("rand%0d latency", g), n, 11);
            checkOutput($sformatf("rand%0d status", g), bus_a.status, refGrade(tw, gw));
            checkOutput($sformatf("rand%0d win", g), bus_a.win, (tw == gw));
            checkOutput($sformatf("rand%0d tries", g), bus_a.tries_left, 5);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/word_guess_checker.md
Name: word_guess_checker

Overview:
- Parametrised successor to the single-letter ASCII comparator: a multi-letter, multi-try word-guess engine.
- Buffers typed letters into a WORD_LEN-letter guess and, on submit, grades each letter against a loaded target word in Wordle style (exact / present elsewhere / absent, duplicate-aware).
- Tracks remaining tries and declares win or lose.
- Sits between the keyboard ASCII decoder and the display/VGA status logic.

Parameters:
- WORD_LEN, 5, letters per word (2..8)
- CHAR_W, 7, bits per ASCII character
- MAX_TRIES, 6, guesses allowed per game (1..2^TRY_W-1)
- TRY_W, 3, width of tries_left

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- load_target  in  1  one-cycle strobe: latch target_word, start new game
- target_word  in  WORD_LEN*CHAR_W  target; letter i at [CHAR_W*i +: CHAR_W], lowercase a–z
- ascii  in  CHAR_W  typed character
- ascii_valid  in  1  ascii is valid this cycle
- backspace  in  1  delete last buffered letter
- submit  in  1  grade the current guess
- ascii_out  out  CHAR_W  last accepted (case-folded) letter, echo for display
- cur_len  out  4  letters currently buffered (0..WORD_LEN)
- status  out  2*WORD_LEN  letter i grade at [2i+1:2i]: 10 exact, 01 present, 00 absent, 11 ungraded
- result_valid  out  1  one-cycle pulse when status is updated
- set  out  1  high while the engine is in ENTRY (ready for input)
- wrong  out  1  one-cycle pulse on rejected input
- win  out  1  sticky, game won
- lose  out  1  sticky, tries exhausted without win
- tries_left  out  TRY_W  remaining guesses

Behaviour:
- Reset (rst=0, asynchronous) values:
  - state IDLE; guess buffer, cur_len, ascii_out = 0
  - status = all 11; result_valid, set, wrong, win, lose = 0; tries_left = 0
- FSM states: IDLE, ENTRY, EVAL_EXACT, EVAL_PRESENT, REPORT, DONE.
- load_target:
  - Accepted in every state except during reset; dominates all other inputs in the same cycle.
  - Latches the target, clears the buffer and cur_len, sets status all 11, tries_left=MAX_TRIES, clears win/lose.
  - Next state is ENTRY.
- ENTRY (set=1); per-cycle input priority is backspace > submit > ascii_valid:
  - backspace: cur_len>0 → decrement, no wrong. cur_len=0 → wrong pulse.
  - ascii_valid, ascii in 'a'–'z' and cur_len<WORD_LEN → store at index cur_len, cur_len+1, ascii_out=ascii.
  - ascii_valid, ascii in 'A'–'Z' → folded to lowercase (bit 5 set), then handled as above.
  - ascii_valid with any other character, or with the buffer full → wrong pulse, buffer unchanged.
  - submit with cur_len<WORD_LEN → wrong pulse, stay in ENTRY.
  - submit with cur_len==WORD_LEN → EVAL_EXACT, index=0, all used flags cleared.
- EVAL_EXACT: one letter per cycle, WORD_LEN cycles.
  - guess[i]==target[i] → grade[i]=10 and used[i]=1; else grade[i]=00.
- EVAL_PRESENT: one guess letter per cycle, WORD_LEN cycles.
  - For each i with grade[i]≠10, search combinationally for the lowest j with used[j]=0 and target[j]==guess[i].
  - Match found → grade[i]=01, used[j]=1.
- REPORT: one cycle.
  - status ← grades; result_valid=1; tries_left decrements.
  - All exact → win=1, go to DONE.
  - Else tries_left reaches 0 → lose=1, go to DONE.
  - Else clear the buffer, cur_len=0, go to ENTRY.
- Latency: submit sampled on edge 0 → result_valid high during cycle 2*WORD_LEN+1.
- All inputs except load_target are ignored, with no wrong pulse, in IDLE, EVAL_*, REPORT and DONE.
- DONE holds status, win/lose and tries_left until load_target or reset.
- Reset asserted mid-evaluation aborts immediately to reset values; no result_valid is produced.
- tries_left never wraps below 0.

Test Plan:
- Reset, load "crane", type c,a,r,e,t, submit → result_valid exactly 11 cycles after the submit edge; status letters 0..4 = 10,01,01,01,00; tries_left=5; win=0.
- Load "apple", guess "ppppp" → status 00,10,10,00,00 (duplicate p not over-credited).
- Load "crane", guess "eerie" → status 00,00,01,00,10.
- Entry edge cases:
  - Type "CR" → ascii_out=7'h72, cur_len=2.
  - Type '1' → wrong pulse, cur_len=2.
  - submit at cur_len=2 → wrong pulse, no evaluation.
  - backspace + ascii_valid same cycle → cur_len=1.
  - 6th letter on a full buffer → wrong pulse.
- MAX_TRIES=2, load "crane", guess "zzzzz" twice → second REPORT gives lose=1, tries_left=0; further submits are ignored. Then load_target "zzzzz" → tries_left=2, lose=0, set=1.
- Guess "crane" on target "crane" → status all 10, win=1, DONE. rst pulsed low during a later EVAL_PRESENT → all outputs return to reset values asynchronously, no result_valid.
